// File: rtl/exu_csr_ctrl.sv
// CSR instruction sequencer: serialises one CSR op behind older work, registers the CSR read,
// then drives the CSR execute unit until write-back accepts. Flush squashes the op at any point.
//
// state   | meaning
// S_IDLE  | waiting for dispatch, ready when not flushing
// S_DRAIN | waiting for older instructions to retire, timeout counter running
// S_READ  | CSR read address stable, read data sampled at end of cycle
// S_EXEC  | request to CSR unit, stalls until WB accepts rd write
module exu_csr_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int RADDR_W   = 5,
    parameter int CID_W     = 3,
    parameter int DRAIN_MAX = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_valid_i,
    output logic               disp_ready_o,
    input  logic [ADDR_W-1:0]  disp_csr_addr_i,
    input  logic [DATA_W-1:0]  disp_op1_i,
    input  logic [2:0]         disp_op_i,
    input  logic               disp_csr_we_i,
    input  logic               disp_reg_we_i,
    input  logic [RADDR_W-1:0] disp_reg_waddr_i,
    input  logic [CID_W-1:0]   disp_cid_i,
    input  logic               older_busy_i,
    input  logic               flush_i,
    output logic [ADDR_W-1:0]  csr_raddr_o,
    input  logic [DATA_W-1:0]  csr_rdata_i,
    output logic               req_csr_o,
    output logic [DATA_W-1:0]  csr_op1_o,
    output logic               csr_csrrw_o,
    output logic               csr_csrrs_o,
    output logic               csr_csrrc_o,
    output logic [DATA_W-1:0]  csr_rdata_o,
    output logic               csr_we_o,
    output logic [ADDR_W-1:0]  csr_waddr_o,
    output logic               csr_reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic [CID_W-1:0]   commit_id_o,
    input  logic               wb_ready_i,
    output logic               busy_o,
    output logic               drain_timeout_o
);

    localparam int CNT_W = $clog2(DRAIN_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DRAIN_MAX);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DRAIN_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_READ  = 2'd2,
        S_EXEC  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    op1_q, op1_d;
    logic [2:0]           op_q, op_d;
    logic                 csr_we_q, csr_we_d;
    logic                 reg_we_q, reg_we_d;
    logic [RADDR_W-1:0]   rd_q, rd_d;
    logic [CID_W-1:0]     cid_q, cid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic accept;
    logic op_onehot;
    logic commit;
    logic in_exec;
    logic live;

    always_comb begin
        live         = ~rst;
        in_exec      = (state_q == S_EXEC);
        commit       = ~reg_we_q | wb_ready_i;
        disp_ready_o = (state_q == S_IDLE) & ~flush_i & live;
        accept       = disp_valid_i & disp_ready_o;
        op_onehot    = (disp_op_i == 3'b001) | (disp_op_i == 3'b010) | (disp_op_i == 3'b100);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        op1_d    = op1_q;
        op_d     = op_q;
        csr_we_d = csr_we_q;
        reg_we_d = reg_we_q;
        rd_d     = rd_q;
        cid_d    = cid_q;
        rdata_d  = rdata_q;

        if (flush_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (accept) begin
                        state_d  = S_DRAIN;
                        addr_d   = disp_csr_addr_i;
                        op1_d    = disp_op1_i;
                        op_d     = disp_op_i;
                        // malformed op decode must never reach the CSR file as a write
                        csr_we_d = disp_csr_we_i & op_onehot;
                        reg_we_d = disp_reg_we_i;
                        rd_d     = disp_reg_waddr_i;
                        cid_d    = disp_cid_i;
                    end
                end
                S_DRAIN: begin
                    if (!older_busy_i) begin
                        state_d = S_READ;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_READ: begin
                    rdata_d = csr_rdata_i;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    if (commit) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            op1_q    <= '0;
            op_q     <= '0;
            csr_we_q <= 1'b0;
            reg_we_q <= 1'b0;
            rd_q     <= '0;
            cid_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            op1_q    <= op1_d;
            op_q     <= op_d;
            csr_we_q <= csr_we_d;
            reg_we_q <= reg_we_d;
            rd_q     <= rd_d;
            cid_q    <= cid_d;
            rdata_q  <= rdata_d;
        end
    end

    // outputs forced low during reset so a mid-operation reset cannot emit a write
    always_comb begin
        busy_o          = (state_q != S_IDLE) & live;
        req_csr_o       = in_exec & live;
        csr_raddr_o     = (live && state_q != S_IDLE) ? addr_q : '0;
        csr_reg_we_o    = in_exec & reg_we_q & ~flush_i & live;
        csr_we_o        = in_exec & csr_we_q & commit & ~flush_i & live;
        drain_timeout_o = (state_q == S_DRAIN) & older_busy_i & ~flush_i & (cnt_q == CNT_TC) & live;
        csr_op1_o       = live ? op1_q : '0;
        csr_csrrw_o     = op_q[0] & live;
        csr_csrrs_o     = op_q[1] & live;
        csr_csrrc_o     = op_q[2] & live;
        csr_rdata_o     = live ? rdata_q : '0;
        csr_waddr_o     = live ? addr_q : '0;
        reg_waddr_o     = live ? rd_q : '0;
        commit_id_o     = live ? cid_q : '0;
    end

endmodule

// File: tb/tb_exu_csr_ctrl.sv
// Bench for exu_csr_ctrl: a per-cycle reference model of the instruction lifecycle checked at
// every falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_exu_csr_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int RW   = 5;
    localparam int CW   = 3;
    localparam int DMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          disp_valid_i = 0;
    logic          disp_ready_o;
    logic [AW-1:0] disp_csr_addr_i = '0;
    logic [DW-1:0] disp_op1_i = '0;
    logic [2:0]    disp_op_i = '0;
    logic          disp_csr_we_i = 0;
    logic          disp_reg_we_i = 0;
    logic [RW-1:0] disp_reg_waddr_i = '0;
    logic [CW-1:0] disp_cid_i = '0;
    logic          older_busy_i = 0;
    logic          flush_i = 0;
    logic [AW-1:0] csr_raddr_o;
    logic [DW-1:0] csr_rdata_i = '0;
    logic          req_csr_o;
    logic [DW-1:0] csr_op1_o;
    logic          csr_csrrw_o, csr_csrrs_o, csr_csrrc_o;
    logic [DW-1:0] csr_rdata_o;
    logic          csr_we_o;
    logic [AW-1:0] csr_waddr_o;
    logic          csr_reg_we_o;
    logic [RW-1:0] reg_waddr_o;
    logic [CW-1:0] commit_id_o;
    logic          wb_ready_i = 1;
    logic          busy_o;
    logic          drain_timeout_o;

    exu_csr_ctrl #(.DATA_W(DW), .ADDR_W(AW), .RADDR_W(RW), .CID_W(CW), .DRAIN_MAX(DMAX)) dut (
        .clk(clk), .rst(rst),
        .disp_valid_i(disp_valid_i), .disp_ready_o(disp_ready_o),
        .disp_csr_addr_i(disp_csr_addr_i), .disp_op1_i(disp_op1_i), .disp_op_i(disp_op_i),
        .disp_csr_we_i(disp_csr_we_i), .disp_reg_we_i(disp_reg_we_i),
        .disp_reg_waddr_i(disp_reg_waddr_i), .disp_cid_i(disp_cid_i),
        .older_busy_i(older_busy_i), .flush_i(flush_i),
        .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
        .req_csr_o(req_csr_o), .csr_op1_o(csr_op1_o),
        .csr_csrrw_o(csr_csrrw_o), .csr_csrrs_o(csr_csrrs_o), .csr_csrrc_o(csr_csrrc_o),
        .csr_rdata_o(csr_rdata_o), .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o),
        .csr_reg_we_o(csr_reg_we_o), .reg_waddr_o(reg_waddr_o), .commit_id_o(commit_id_o),
        .wb_ready_i(wb_ready_i), .busy_o(busy_o), .drain_timeout_o(drain_timeout_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: instruction held / older work drained / CSR value read
    bit            m_has, m_drained, m_read;
    int            m_cnt;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_op1, m_rdata;
    logic [2:0]    m_op;
    bit            m_csr_we, m_reg_we;
    logic [RW-1:0] m_rd;
    logic [CW-1:0] m_cid;
    bit            chk_en = 0;

    always @(posedge clk) begin
        chk_en = 1;
        if (rst) begin
            m_has = 0; m_drained = 0; m_read = 0; m_cnt = 0;
            m_addr = '0; m_op1 = '0; m_rdata = '0; m_op = '0;
            m_csr_we = 0; m_reg_we = 0; m_rd = '0; m_cid = '0;
        end else if (flush_i) begin
            m_has = 0;
            m_cnt = 0;
        end else if (!m_has) begin
            if (disp_valid_i) begin
                m_has = 1; m_drained = 0; m_read = 0; m_cnt = 0;
                m_addr = disp_csr_addr_i; m_op1 = disp_op1_i; m_op = disp_op_i;
                m_csr_we = disp_csr_we_i && ($countones(disp_op_i) == 1);
                m_reg_we = disp_reg_we_i; m_rd = disp_reg_waddr_i; m_cid = disp_cid_i;
            end
        end else if (!m_drained) begin
            if (!older_busy_i) begin
                m_drained = 1;
                m_cnt = 0;
            end else if (m_cnt < DMAX) begin
                m_cnt++;
            end
        end else if (!m_read) begin
            m_rdata = csr_rdata_i;
            m_read = 1;
        end else if (!m_reg_we || wb_ready_i) begin
            m_has = 0;
        end
    end

    always @(negedge clk) begin : cmp
        bit live, idle_e, drn_e, ex_e, cm;
        if (chk_en) begin
            live   = !rst;
            idle_e = !m_has;
            drn_e  = m_has && !m_drained;
            ex_e   = m_has && m_read;
            cm     = !m_reg_we || wb_ready_i;
            chk("ready",      disp_ready_o,    live && idle_e && !flush_i);
            chk("busy",       busy_o,          live && m_has);
            chk("req",        req_csr_o,       live && ex_e);
            chk("raddr",      csr_raddr_o,     (live && m_has) ? m_addr : '0);
            chk("csr_we",     csr_we_o,        live && ex_e && m_csr_we && cm && !flush_i);
            chk("reg_we",     csr_reg_we_o,    live && ex_e && m_reg_we && !flush_i);
            chk("timeout",    drain_timeout_o, live && drn_e && older_busy_i && !flush_i && (m_cnt + 1 == DMAX));
            chk("op1",        csr_op1_o,       live ? m_op1 : '0);
            chk("csrrw",      csr_csrrw_o,     live && m_op[0]);
            chk("csrrs",      csr_csrrs_o,     live && m_op[1]);
            chk("csrrc",      csr_csrrc_o,     live && m_op[2]);
            chk("rdata",      csr_rdata_o,     live ? m_rdata : '0);
            chk("waddr",      csr_waddr_o,     live ? m_addr : '0);
            chk("reg_waddr",  reg_waddr_o,     live ? m_rd : '0);
            chk("commit_id",  commit_id_o,     live ? m_cid : '0);
        end
    end

    // Event counters observed from the DUT for the scenario-level literal checks
    int n_we, n_regwe, n_busy, n_prereq, n_to, n_acc, n_we_lowwb;

    always @(negedge clk) begin
        if (csr_we_o) n_we++;
        if (csr_we_o && !wb_ready_i) n_we_lowwb++;
        if (csr_reg_we_o) n_regwe++;
        if (busy_o) n_busy++;
        if (busy_o && !req_csr_o) n_prereq++;
        if (drain_timeout_o) n_to++;
        if (disp_valid_i && disp_ready_o) n_acc++;
    end

    task automatic clear_counts();
        n_we = 0; n_regwe = 0; n_busy = 0; n_prereq = 0; n_to = 0; n_acc = 0; n_we_lowwb = 0;
    endtask

    // called at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after accept
    task automatic offer(input logic [AW-1:0] addr, input logic [DW-1:0] op1, input logic [2:0] op,
                         input logic cwe, input logic rwe, input logic [RW-1:0] rd,
                         input logic [CW-1:0] cid);
        disp_csr_addr_i = addr; disp_op1_i = op1; disp_op_i = op;
        disp_csr_we_i = cwe; disp_reg_we_i = rwe; disp_reg_waddr_i = rd; disp_cid_i = cid;
        disp_valid_i = 1;
        @(posedge clk); #1;
        disp_valid_i = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while (busy_o && n < 200) begin
            step();
            n++;
        end
        tests++;
        if (busy_o) begin
            fails++;
            $display("FAIL %s_idle_timeout actual=busy required=idle", nm);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        chk("rst_ready",  disp_ready_o, 0);
        chk("rst_busy",   busy_o, 0);
        chk("rst_rdata",  csr_rdata_o, 0);
        rst = 0;
        step();
        chk("post_rst_ready", disp_ready_o, 1);

        // basic csrrw, minimum latency
        clear_counts();
        offer(32'h300, 32'h5, 3'b001, 1, 1, 5'd3, 3'd1);
        chk("t1_busy_c1", busy_o, 1);
        step();
        step();
        chk("t1_req_c3",    req_csr_o, 1);
        chk("t1_we_c3",     csr_we_o, 1);
        chk("t1_regwe_c3",  csr_reg_we_o, 1);
        chk("t1_op1",       csr_op1_o, 32'h5);
        chk("t1_waddr",     csr_waddr_o, 32'h300);
        chk("t1_rd",        reg_waddr_o, 5'd3);
        wait_idle("t1");
        chk("t1_n_we",    n_we, 1);
        chk("t1_n_regwe", n_regwe, 1);
        chk("t1_n_busy",  n_busy, 3);

        // long drain with timeout at count 4
        clear_counts();
        older_busy_i = 1;
        offer(32'h341, 32'h1, 3'b010, 1, 1, 5'd4, 3'd2);
        repeat (9) step();
        older_busy_i = 0;
        wait_idle("t2");
        chk("t2_n_prereq", n_prereq, 11);
        chk("t2_n_busy",   n_busy, 12);
        chk("t2_n_to",     n_to, 1);

        // WB back-pressure for 5 EXEC cycles
        clear_counts();
        wb_ready_i = 0;
        offer(32'h305, 32'hF0, 3'b100, 1, 1, 5'd6, 3'd3);
        repeat (7) step();
        wb_ready_i = 1;
        wait_idle("t3");
        chk("t3_n_regwe",    n_regwe, 6);
        chk("t3_n_we",       n_we, 1);
        chk("t3_we_lowwb",   n_we_lowwb, 0);
        chk("t3_n_busy",     n_busy, 8);

        // read data captured in READ and held through EXEC
        clear_counts();
        csr_rdata_i = 32'hA5;
        wb_ready_i = 0;
        offer(32'h340, 32'h0F, 3'b010, 1, 1, 5'd7, 3'd4);
        step();
        step();
        csr_rdata_i = 32'h33;
        step();
        chk("t4_rdata_held", csr_rdata_o, 32'hA5);
        chk("t4_csrrs",      csr_csrrs_o, 1);
        chk("t4_op1",        csr_op1_o, 32'h0F);
        chk("t4_req",        req_csr_o, 1);
        wb_ready_i = 1;
        wait_idle("t4");
        chk("t4_n_we", n_we, 1);

        // flush in DRAIN, READ and EXEC
        clear_counts();
        offer(32'h300, 32'h1, 3'b001, 1, 1, 5'd1, 3'd5);
        flush_i = 1;
        step();
        flush_i = 0;
        chk("t5_drain_flush_idle", busy_o, 0);
        offer(32'h300, 32'h2, 3'b001, 1, 1, 5'd1, 3'd6);
        step();
        flush_i = 1;
        step();
        flush_i = 0;
        chk("t5_read_flush_idle", busy_o, 0);
        offer(32'h300, 32'h3, 3'b001, 1, 1, 5'd1, 3'd7);
        step();
        step();
        flush_i = 1;
        #1;
        chk("t5_exec_flush_we",    csr_we_o, 0);
        chk("t5_exec_flush_regwe", csr_reg_we_o, 0);
        chk("t5_exec_flush_ready", disp_ready_o, 0);
        step();
        flush_i = 0;
        chk("t5_exec_flush_idle", busy_o, 0);
        chk("t5_n_we",    n_we, 0);
        chk("t5_n_regwe", n_regwe, 0);

        // invalid op decode: no CSR write, rd write kept
        clear_counts();
        csr_rdata_i = 32'h77;
        offer(32'h344, 32'h9, 3'b000, 1, 1, 5'd9, 3'd0);
        wait_idle("t6a");
        chk("t6_n_we",    n_we, 0);
        chk("t6_n_regwe", n_regwe, 1);
        chk("t6_rdata",   csr_rdata_o, 32'h77);
        clear_counts();
        offer(32'h344, 32'h9, 3'b110, 1, 0, 5'd9, 3'd1);
        wait_idle("t6b");
        chk("t6_multi_n_we", n_we, 0);

        // dispatch held valid: back-to-back accepts at c0 and c4
        clear_counts();
        disp_op_i = 3'b001; disp_csr_we_i = 1; disp_reg_we_i = 1;
        disp_valid_i = 1;
        repeat (8) step();
        disp_valid_i = 0;
        wait_idle("t7");
        chk("t7_n_acc", n_acc, 2);
        chk("t7_n_we",  n_we, 2);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
